tmds_decoder: RTL and testbench

Receive-side TMDS channel decoder for the DVI/HDMI output path. It takes raw 10-bit words from a deserializer whose word boundary is unknown, locks symbol alignment using the four control tokens, and decodes each aligned symbol back into 8-bit pixel data or a C1/C0 control pair. It also flags symbols that violate the transition-minimisation rule. One instance sits on each colour channel and acts as the loopback/verification counterpart of the channel encoder.

---
 rtl/tmds_pkg.sv | 26 ++
 rtl/tmds_symbol_decode.sv | 39 +++
 rtl/tmds_decoder.sv | 176 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, alignment FSM states and the
// transition-minimisation rule used by both the decoder and the encoder bench.
package tmds_pkg;

   localparam logic [9:0] TOK_C00 = 10'b1101010100;
   localparam logic [9:0] TOK_C01 = 10'b0010101011;
   localparam logic [9:0] TOK_C10 = 10'b0101010100;
   localparam logic [9:0] TOK_C11 = 10'b1010101011;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   // Bit 8 an encoder must emit for this byte: 0 selects the XNOR chain.
   function automatic logic exp_sym8(input logic [7:0] d);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, d[i]};
      end
      return ((n > 4'd4) || ((n == 4'd4) && (d[0] == 1'b0))) ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into token or data
// fields, with a flag for data symbols whose bit 8 contradicts the byte.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] sym_i,
   output logic       is_token_o,
   output logic       c1_o,
   output logic       c0_o,
   output logic [7:0] d_o,
   output logic       err_o
);

   logic [7:0] q_m_s;
   logic [7:0] d_s;

   // Token match, data recovery and validity check.
   always_comb begin
      is_token_o = 1'b0;
      c1_o       = 1'b0;
      c0_o       = 1'b0;
      case (sym_i)
         TOK_C00: is_token_o = 1'b1;
         TOK_C01: begin is_token_o = 1'b1; c0_o = 1'b1; end
         TOK_C10: begin is_token_o = 1'b1; c1_o = 1'b1; end
         TOK_C11: begin is_token_o = 1'b1; c1_o = 1'b1; c0_o = 1'b1; end
         default: is_token_o = 1'b0;
      endcase
      q_m_s  = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
      d_s    = 8'd0;
      d_s[0] = q_m_s[0];
      for (int i = 1; i < 8; i++) begin
         d_s[i] = sym_i[8] ? (q_m_s[i] ^ q_m_s[i-1]) : ~(q_m_s[i] ^ q_m_s[i-1]);
      end
      d_o   = d_s;
      err_o = !is_token_o && (sym_i[8] != exp_sym8(d_s));
   end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: word history, token-based alignment FSM and
// registered decode outputs, two cycles behind the accepted word.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_COUNT = 8,
   parameter int MISS_LIMIT = 16,
   parameter int ERR_LIMIT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] sym_in,
   input  logic       sym_valid,
   output logic [7:0] d_out,
   output logic       de,
   output logic       c0,
   output logic       c1,
   output logic       out_valid,
   output logic       sym_err,
   output logic       locked,
   output logic [3:0] align_offset
);

   localparam int TW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_COUNT - 1);
   localparam logic [TW-1:0] TOK_FULL  = TW'(LOCK_COUNT);
   localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

   logic [19:0]   hist_q;
   logic          pend_q;
   state_e        state_q, state_d;
   logic [TW-1:0] tok_cnt_q, tok_cnt_d;
   logic [MW-1:0] miss_cnt_q, miss_cnt_d;
   logic [EW-1:0] err_cnt_q, err_cnt_d;
   logic [3:0]    offset_q, offset_d;
   logic [7:0]    d_out_q;
   logic          de_q, c0_q, c1_q, out_valid_q, sym_err_q, locked_q;

   logic [9:0]    aligned_s;
   logic [3:0]    next_off_s;
   logic          tok_s, c1_s, c0_s, err_s, emit_s;
   logic [7:0]    dec_d_s;

   assign aligned_s  = 10'(hist_q >> offset_q);
   assign next_off_s = (offset_q >= 4'd9) ? 4'd0 : (offset_q + 4'd1);

   tmds_symbol_decode u_dec (
      .sym_i      (aligned_s),
      .is_token_o (tok_s),
      .c1_o       (c1_s),
      .c0_o       (c0_s),
      .d_o        (dec_d_s),
      .err_o      (err_s)
   );

   // Alignment FSM; steps once for each word that landed in hist last cycle.
   always_comb begin
      state_d    = state_q;
      tok_cnt_d  = tok_cnt_q;
      miss_cnt_d = miss_cnt_q;
      err_cnt_d  = err_cnt_q;
      offset_d   = offset_q;
      emit_s     = 1'b0;
      if (pend_q) begin
         case (state_q)
            SEARCH: begin
               if (tok_s) begin
                  state_d    = VERIFY;
                  tok_cnt_d  = TW'(1'b1);
                  miss_cnt_d = '0;
               end else if (miss_cnt_q >= MISS_LAST) begin
                  offset_d   = next_off_s;
                  miss_cnt_d = '0;
               end else begin
                  miss_cnt_d = miss_cnt_q + MW'(1'b1);
               end
            end
            VERIFY: begin
               if (!tok_s) begin
                  state_d    = SEARCH;
                  offset_d   = next_off_s;
                  tok_cnt_d  = '0;
                  miss_cnt_d = '0;
                  err_cnt_d  = '0;
               end else if (tok_cnt_q >= TOK_LAST) begin
                  state_d   = LOCKED;
                  tok_cnt_d = TOK_FULL;
                  emit_s    = 1'b1;
               end else begin
                  tok_cnt_d = tok_cnt_q + TW'(1'b1);
               end
            end
            LOCKED: begin
               emit_s = 1'b1;
               if (!err_s) begin
                  err_cnt_d = '0;
               end else if (err_cnt_q >= ERR_LAST) begin
                  state_d    = SEARCH;
                  offset_d   = next_off_s;
                  tok_cnt_d  = '0;
                  miss_cnt_d = '0;
                  err_cnt_d  = '0;
               end else begin
                  err_cnt_d = err_cnt_q + EW'(1'b1);
               end
            end
            default: begin
               state_d    = SEARCH;
               tok_cnt_d  = '0;
               miss_cnt_d = '0;
               err_cnt_d  = '0;
            end
         endcase
      end else begin
         emit_s = 1'b0;
      end
   end

   // History, FSM state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q      <= 20'd0;
         pend_q      <= 1'b0;
         state_q     <= SEARCH;
         tok_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         err_cnt_q   <= '0;
         offset_q    <= 4'd0;
         d_out_q     <= 8'd0;
         de_q        <= 1'b0;
         c0_q        <= 1'b0;
         c1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         sym_err_q   <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         if (sym_valid) begin
            hist_q <= {sym_in, hist_q[19:10]};
         end
         pend_q      <= sym_valid;
         state_q     <= state_d;
         tok_cnt_q   <= tok_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         offset_q    <= offset_d;
         locked_q    <= (state_d == LOCKED);
         out_valid_q <= emit_s;
         sym_err_q   <= emit_s & err_s;
         // The symbol that drops lock is still emitted; zeros follow once unlocked.
         if (emit_s) begin
            de_q    <= ~tok_s;
            d_out_q <= tok_s ? 8'd0 : dec_d_s;
            c1_q    <= tok_s & c1_s;
            c0_q    <= tok_s & c0_s;
         end else if (state_q != LOCKED) begin
            de_q    <= 1'b0;
            d_out_q <= 8'd0;
            c1_q    <= 1'b0;
            c0_q    <= 1'b0;
         end
      end
   end

   assign d_out        = d_out_q;
   assign de           = de_q;
   assign c0           = c0_q;
   assign c1           = c1_q;
   assign out_valid    = out_valid_q;
   assign sym_err      = sym_err_q;
   assign locked       = locked_q;
   assign align_offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: directed tables and sequences plus a
// randomized stream, all compared every cycle against a word-level reference model.
module tb_tmds_decoder;

   localparam int LOCKN = 8;
   localparam int MISSN = 16;
   localparam int ERRN  = 4;
   localparam int M_SEARCH = 0;
   localparam int M_VERIFY = 1;
   localparam int M_LOCKED = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       sym_valid;
   logic [9:0] sym_in;
   logic [7:0] d_out;
   logic       de, c0, c1, out_valid, sym_err, locked;
   logic [3:0] align_offset;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tmds_decoder #(.LOCK_COUNT(LOCKN), .MISS_LIMIT(MISSN), .ERR_LIMIT(ERRN)) dut (
      .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
      .d_out(d_out), .de(de), .c0(c0), .c1(c1), .out_valid(out_valid),
      .sym_err(sym_err), .locked(locked), .align_offset(align_offset)
   );

   // reference model state: the last two accepted words and the alignment rules
   logic [9:0] toks [4];
   int         m_st, m_tok, m_miss, m_err, m_off;
   bit         m_pend;
   logic [9:0] m_new, m_old;
   logic [7:0] e_d;
   logic       e_de, e_c1, e_c0, e_ov, e_se;

   typedef struct {
      logic [9:0]  sym;
      logic [11:0] exp;   // {sym_err, de, c1, c0, d_out}
   } vec_t;
   vec_t vecs [11];

   function automatic int tok_index(logic [9:0] w);
      for (int c = 0; c < 4; c++) if (w == toks[c]) return c;
      return -1;
   endfunction

   function automatic logic [7:0] ref_data(logic [9:0] w);
      logic [7:0] q, d;
      q = w[9] ? ~w[7:0] : w[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
      return d;
   endfunction

   function automatic bit ref_bad(logic [9:0] w, logic [7:0] d);
      int n;
      bit want_xnor;
      n = $countones(d);
      want_xnor = (n > 4) || (n == 4 && d[0] == 1'b0);
      return (w[8] == 1'b1) == want_xnor;
   endfunction

   function automatic logic [9:0] enc(logic [7:0] d, logic inv);
      int n;
      logic use_xnor;
      logic [7:0] q;
      n = $countones(d);
      use_xnor = (n > 4) || (n == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? !(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      return {inv, !use_xnor, inv ? ~q : q};
   endfunction

   task automatic m_edge();
      logic [19:0] win;
      logic [9:0]  w;
      logic [7:0]  d;
      int          c, was;
      bit          err, emit;
      if (rst) begin
         m_st = M_SEARCH; m_tok = 0; m_miss = 0; m_err = 0; m_off = 0;
         m_pend = 0; m_new = 10'd0; m_old = 10'd0;
         e_d = 8'd0; e_de = 1'b0; e_c1 = 1'b0; e_c0 = 1'b0; e_ov = 1'b0; e_se = 1'b0;
         return;
      end
      emit = 0; err = 0; c = -1; d = 8'd0; was = m_st;
      if (m_pend) begin
         win = {m_new, m_old};
         w   = win[m_off +: 10];
         c   = tok_index(w);
         d   = ref_data(w);
         err = (c < 0) && ref_bad(w, d);
         if (m_st == M_SEARCH) begin
            if (c >= 0) begin m_st = M_VERIFY; m_tok = 1; m_miss = 0; end
            else begin
               m_miss++;
               if (m_miss == MISSN) begin m_off = (m_off + 1) % 10; m_miss = 0; end
            end
         end else if (m_st == M_VERIFY) begin
            if (c >= 0) begin
               m_tok++;
               if (m_tok == LOCKN) begin m_st = M_LOCKED; emit = 1; end
            end else begin
               m_st = M_SEARCH; m_off = (m_off + 1) % 10; m_tok = 0; m_miss = 0; m_err = 0;
            end
         end else begin
            emit = 1;
            if (err) begin
               m_err++;
               if (m_err == ERRN) begin
                  m_st = M_SEARCH; m_off = (m_off + 1) % 10; m_tok = 0; m_miss = 0; m_err = 0;
               end
            end else m_err = 0;
         end
      end
      e_ov = emit;
      e_se = emit && err;
      if (emit) begin
         e_de = (c < 0);
         e_d  = (c < 0) ? d : 8'd0;
         e_c1 = (c == 2 || c == 3);
         e_c0 = (c == 1 || c == 3);
      end else if (was != M_LOCKED) begin
         e_d = 8'd0; e_de = 1'b0; e_c1 = 1'b0; e_c0 = 1'b0;
      end
      if (sym_valid) begin m_old = m_new; m_new = sym_in; end
      m_pend = sym_valid;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic [17:0] act, exp;
      @(posedge clk);
      m_edge();
      #1;
      act = {d_out, de, c1, c0, out_valid, sym_err, locked, align_offset};
      exp = {e_d, e_de, e_c1, e_c0, e_ov, e_se, logic'(m_st == M_LOCKED), 4'(m_off)};
      chk("model", 32'(act), 32'(exp));
   endtask

   task automatic drive(logic v, logic [9:0] w);
      sym_valid = v;
      sym_in    = w;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; sym_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] t, w;
      int pos, nv;
      toks[0] = 10'b1101010100;
      toks[1] = 10'b0010101011;
      toks[2] = 10'b0101010100;
      toks[3] = 10'b1010101011;
      vecs[0]  = '{10'h100,        {1'b0, 1'b1, 2'b00, 8'h00}};
      vecs[1]  = '{10'h200,        {1'b0, 1'b1, 2'b00, 8'hFF}};
      vecs[2]  = '{10'h155,        {1'b1, 1'b1, 2'b00, 8'hFF}};
      vecs[3]  = '{10'b0010101011, {1'b0, 1'b0, 2'b01, 8'h00}};
      vecs[4]  = '{10'h1FF,        {1'b0, 1'b1, 2'b00, 8'h01}};
      vecs[5]  = '{10'b0101010100, {1'b0, 1'b0, 2'b10, 8'h00}};
      vecs[6]  = '{10'h0FF,        {1'b0, 1'b1, 2'b00, 8'hFF}};
      vecs[7]  = '{10'h2AA,        {1'b1, 1'b1, 2'b00, 8'h01}};
      vecs[8]  = '{10'b1010101011, {1'b0, 1'b0, 2'b11, 8'h00}};
      vecs[9]  = '{10'h300,        {1'b0, 1'b1, 2'b00, 8'h01}};
      vecs[10] = '{10'h000,        {1'b0, 1'b1, 2'b00, 8'hFE}};

      // reset dominates a valid input
      rst = 1'b1; sym_valid = 1'b1; sym_in = toks[0];
      tick();
      tick();
      chk("reset", 32'({d_out, de, c1, c0, out_valid, sym_err, locked, align_offset}), 32'd0);
      rst = 1'b0;

      // lock on C00 tokens at offset 0
      for (int k = 1; k <= 9; k++) drive(1'b1, toks[0]);
      chk("prelock", 32'(locked), 32'd0);
      drive(1'b1, toks[0]);
      chk("lock", 32'({locked, out_valid, de, c1, c0, align_offset}), 32'({1'b1, 1'b1, 1'b0, 2'b00, 4'd0}));

      // decode table while locked; each word appears two accepts later
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, (i < 11) ? vecs[i].sym : toks[0]);
         if (i >= 2)
            chk($sformatf("vec%0d", i - 2), 32'({out_valid, sym_err, de, c1, c0, d_out}),
                32'({1'b1, vecs[i-2].exp}));
      end

      // four invalid symbols in a row drop lock and advance the offset
      for (int k = 0; k < 4; k++) drive(1'b1, 10'h155);
      drive(1'b1, toks[0]);
      drive(1'b1, toks[0]);
      chk("droplock", 32'({locked, out_valid, sym_err, d_out, align_offset}),
          32'({1'b0, 1'b1, 1'b1, 8'hFF, 4'd1}));
      drive(1'b1, toks[0]);
      chk("unlocked_zero", 32'({d_out, de, c1, c0, out_valid}), 32'd0);

      // gaps between tokens do not disturb locking
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, toks[0]);
         drive(1'b0, 10'h3FF);
         drive(1'b0, 10'h3FF);
         chk($sformatf("gap_ov%0d", k), 32'(out_valid), 32'd0);
      end
      chk("gap_lock", 32'(locked), 32'd1);

      // synchronous reset mid-stream, then a full relock
      drive(1'b1, toks[0]);
      rst = 1'b1; sym_valid = 1'b1; sym_in = toks[0];
      tick();
      rst = 1'b0;
      chk("midrst", 32'({d_out, de, c1, c0, out_valid, sym_err, locked, align_offset}), 32'd0);
      for (int k = 1; k <= 9; k++) drive(1'b1, toks[0]);
      chk("relock_pre", 32'(locked), 32'd0);
      drive(1'b1, toks[0]);
      chk("relock", 32'(locked), 32'd1);

      // C10 token stream slipped by three pad bits
      do_reset();
      t = toks[2];
      for (int j = 0; j < 120; j++) begin
         for (int b = 0; b < 10; b++) begin
            pos  = 10 * j + b;
            w[b] = (pos < 3) ? 1'b0 : t[(pos - 3) % 10];
         end
         drive(1'b1, w);
         if (locked) break;
      end
      chk("walk_lock", 32'({locked, align_offset, de, c1, c0, out_valid}),
          32'({1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1}));

      // randomized mix of tokens, valid data, junk, gaps and rare resets
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else if (n < 15) begin
            drive(1'b1, toks[0]);
         end else if ($urandom_range(0, 99) < 25) begin
            drive(1'b0, 10'($urandom));
         end else begin
            nv = int'($urandom_range(0, 99));
            if (nv < 35)      w = toks[$urandom_range(0, 3)];
            else if (nv < 85) w = enc(8'($urandom), 1'($urandom));
            else              w = 10'($urandom);
            drive(1'b1, w);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
